radar_echo_responder: RTL and testbench

Target-side echo responder for the radar tracking unit: it watches the unit's radar pulse trigger, qualifies a valid pulse by width, and returns a `radar_echo` pulse after a round-trip delay derived from a programmed target distance. It sits on the far end of the radar pulse/echo interface, both as the closed-loop target model in system simulation and as the echo source on the integration bench. It also reports per-shot status (short pulse, out of range) and a count of echoes returned.

---
 rtl/radar_echo_responder.sv | 124 ++++++++++++
 tb/tb_radar_echo_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/radar_echo_responder.sv
// Purpose : target-side echo model; qualifies a radar trigger by width and
//           returns a fixed-width echo after a range-derived round-trip delay.
// Latency : echo rises d+1 cycles after the edge that accepts the shot (d = target_distance >> RANGE_SHIFT).
// Backpres: none; trigger activity outside IDLE is ignored until the shot completes.
//
// Ports:
//   CLK, RST             - clock (rising edge), asynchronous active-high reset
//   radar_pulse_trigger  - pulse from the tracking unit
//   target_distance      - simulated range, sampled on the shot-accepting edge
//   enable               - arms the responder for new shots
//   radar_echo           - echo pulse back to the tracking unit
//   echo_count           - saturating count of echoes issued since reset
//   short_pulse          - one-cycle flag: trigger shorter than MIN_PULSE_CYCLES
//   out_of_range         - one-cycle flag: computed delay exceeds MAX_DELAY
//   responder_state      - IDLE=00, PULSE=01, DELAY=10, ECHO=11
module radar_echo_responder #(
  parameter int unsigned MIN_PULSE_CYCLES = 300,
  parameter int unsigned RANGE_SHIFT      = 4,
  parameter int unsigned MAX_DELAY        = 1999,
  parameter int unsigned ECHO_WIDTH       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic [31:0] target_distance,
  input  logic        enable,
  output logic        radar_echo,
  output logic [15:0] echo_count,
  output logic        short_pulse,
  output logic        out_of_range,
  output logic [1:0]  responder_state
);

  // Delay counter only needs to hold values up to MAX_DELAY; anything larger
  // is rejected before it is loaded.
  localparam int DW = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
  localparam int EW = (ECHO_WIDTH > 1) ? $clog2(ECHO_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    DELAY = 2'b10,
    ECHO  = 2'b11
  } state_t;

  state_t         state;
  logic [15:0]    pulse_cnt;
  logic [DW-1:0]  delay_cnt;
  logic [EW-1:0]  echo_cnt;
  logic [31:0]    dist_shift;

  assign dist_shift      = target_distance >> RANGE_SHIFT;
  assign responder_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      delay_cnt    <= '0;
      echo_cnt     <= '0;
      radar_echo   <= 1'b0;
      echo_count   <= '0;
      short_pulse  <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      // Status flags are single-cycle strobes.
      short_pulse  <= 1'b0;
      out_of_range <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && radar_pulse_trigger) begin
            pulse_cnt <= 16'd1;
            state     <= PULSE;
          end
        end

        PULSE: begin
          if (radar_pulse_trigger) begin
            if (pulse_cnt != 16'hFFFF) begin
              pulse_cnt <= pulse_cnt + 16'd1;
            end
          end else if (pulse_cnt < 16'(MIN_PULSE_CYCLES)) begin
            short_pulse <= 1'b1;
            state       <= IDLE;
          end else if (dist_shift > 32'(MAX_DELAY)) begin
            out_of_range <= 1'b1;
            state        <= IDLE;
          end else begin
            // Range is latched here; later target_distance changes do not
            // affect this shot.
            delay_cnt <= dist_shift[DW-1:0];
            state     <= DELAY;
          end
        end

        DELAY: begin
          if (delay_cnt != '0) begin
            delay_cnt <= delay_cnt - 1'b1;
          end else begin
            radar_echo <= 1'b1;
            echo_cnt   <= EW'(ECHO_WIDTH - 1);
            state      <= ECHO;
          end
        end

        ECHO: begin
          if (echo_cnt != '0) begin
            echo_cnt <= echo_cnt - 1'b1;
          end else begin
            radar_echo <= 1'b0;
            if (echo_count != 16'hFFFF) begin
              echo_count <= echo_count + 16'd1;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_echo_responder.sv
module tb_radar_echo_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        radar_pulse_trigger;
  logic [31:0] target_distance;
  logic        enable;
  logic        radar_echo;
  logic [15:0] echo_count;
  logic        short_pulse;
  logic        out_of_range;
  logic [1:0]  responder_state;

  int vectors     = 0;
  int miscompares = 0;

  radar_echo_responder dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .radar_pulse_trigger (radar_pulse_trigger),
    .target_distance     (target_distance),
    .enable              (enable),
    .radar_echo          (radar_echo),
    .echo_count          (echo_count),
    .short_pulse         (short_pulse),
    .out_of_range        (out_of_range),
    .responder_state     (responder_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n falling edges; inputs change and outputs are sampled there.
  task automatic adv(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Trigger high for exactly n sampled rising edges, then low. On return the
  // next rising edge is E0; adv(k) afterwards samples just after edge E0+k-1.
  task automatic fire(input int n);
    radar_pulse_trigger = 1'b1;
    adv(n);
    radar_pulse_trigger = 1'b0;
  endtask

  initial begin
    RST                 = 1'b1;
    radar_pulse_trigger = 1'b0;
    target_distance     = 32'd0;
    enable              = 1'b0;
    adv(2);
    chk("rst_echo",  {31'd0, radar_echo},   32'd0);
    chk("rst_count", {16'd0, echo_count},   32'd0);
    chk("rst_short", {31'd0, short_pulse},  32'd0);
    chk("rst_oor",   {31'd0, out_of_range}, 32'd0);
    chk("rst_state", {30'd0, responder_state}, 32'd0);
    RST    = 1'b0;
    enable = 1'b1;
    adv(2);

    // Shot 1: 300-cycle trigger, d=100 -> echo high E0+101..E0+104.
    target_distance = 32'd1600;
    fire(300);
    adv(1);
    chk("s1_state_delay", {30'd0, responder_state}, 32'd2);
    chk("s1_short",       {31'd0, short_pulse},     32'd0);
    chk("s1_oor",         {31'd0, out_of_range},    32'd0);
    target_distance = 32'd15; // must not affect the shot in flight
    adv(100);
    chk("s1_echo_pre",   {31'd0, radar_echo}, 32'd0);
    adv(1);
    chk("s1_echo_first", {31'd0, radar_echo}, 32'd1);
    chk("s1_state_echo", {30'd0, responder_state}, 32'd3);
    adv(3);
    chk("s1_echo_last",  {31'd0, radar_echo}, 32'd1);
    adv(1);
    chk("s1_echo_fall",  {31'd0, radar_echo}, 32'd0);
    chk("s1_count",      {16'd0, echo_count}, 32'd1);
    chk("s1_state_idle", {30'd0, responder_state}, 32'd0);

    // Shot 2: 299-cycle trigger -> short pulse, no echo.
    adv(3);
    target_distance = 32'd1600;
    fire(299);
    adv(1);
    chk("s2_short_hi", {31'd0, short_pulse},     32'd1);
    chk("s2_state",    {30'd0, responder_state}, 32'd0);
    adv(1);
    chk("s2_short_lo", {31'd0, short_pulse},     32'd0);
    adv(120);
    chk("s2_echo",     {31'd0, radar_echo},      32'd0);
    chk("s2_count",    {16'd0, echo_count},      32'd1);

    // Shot 3a: d=2000 -> out of range.
    target_distance = 32'd32000;
    fire(300);
    adv(1);
    chk("s3a_oor_hi", {31'd0, out_of_range},    32'd1);
    chk("s3a_state",  {30'd0, responder_state}, 32'd0);
    adv(1);
    chk("s3a_oor_lo", {31'd0, out_of_range},    32'd0);
    adv(2010);
    chk("s3a_echo",   {31'd0, radar_echo},      32'd0);
    chk("s3a_count",  {16'd0, echo_count},      32'd1);

    // Shot 3b: d=1999 -> echo rises after E0+2000.
    target_distance = 32'd31999;
    fire(300);
    adv(1);
    chk("s3b_oor",      {31'd0, out_of_range}, 32'd0);
    adv(1999);
    chk("s3b_echo_pre", {31'd0, radar_echo},   32'd0);
    adv(1);
    chk("s3b_echo_hi",  {31'd0, radar_echo},   32'd1);
    adv(4);
    chk("s3b_echo_lo",  {31'd0, radar_echo},   32'd0);
    chk("s3b_count",    {16'd0, echo_count},   32'd2);

    // Shot 4: d=0 -> echo at E0+1 for 4 cycles.
    target_distance = 32'd15;
    fire(300);
    adv(1);
    chk("s4_state_delay", {30'd0, responder_state}, 32'd2);
    chk("s4_echo_pre",    {31'd0, radar_echo},      32'd0);
    adv(1);
    chk("s4_echo_hi",     {31'd0, radar_echo},      32'd1);
    adv(3);
    chk("s4_echo_last",   {31'd0, radar_echo},      32'd1);
    adv(1);
    chk("s4_echo_lo",     {31'd0, radar_echo},      32'd0);
    chk("s4_count",       {16'd0, echo_count},      32'd3);

    // Shot 5: d=100 with a re-pulse during DELAY -> exactly one echo.
    target_distance = 32'd1600;
    fire(300);
    adv(10);
    radar_pulse_trigger = 1'b1;
    adv(20);
    radar_pulse_trigger = 1'b0;
    chk("s5_state_delay", {30'd0, responder_state}, 32'd2);
    adv(72);
    chk("s5_echo_hi",     {31'd0, radar_echo},      32'd1);
    adv(4);
    chk("s5_echo_lo",     {31'd0, radar_echo},      32'd0);
    chk("s5_count",       {16'd0, echo_count},      32'd4);
    adv(400);
    chk("s5_no_second",   {16'd0, echo_count},      32'd4);
    chk("s5_state_idle",  {30'd0, responder_state}, 32'd0);

    // Shot 6: enable=0 with a 500-cycle trigger -> ignored.
    enable = 1'b0;
    radar_pulse_trigger = 1'b1;
    adv(250);
    chk("s6_state_mid", {30'd0, responder_state}, 32'd0);
    adv(250);
    radar_pulse_trigger = 1'b0;
    adv(2);
    chk("s6_state",     {30'd0, responder_state}, 32'd0);
    chk("s6_short",     {31'd0, short_pulse},     32'd0);
    chk("s6_count",     {16'd0, echo_count},      32'd4);

    // Shot 7: enable dropped during DELAY -> echo still issued.
    enable = 1'b1;
    adv(1);
    fire(300);
    adv(5);
    enable = 1'b0;
    adv(97);
    chk("s7_echo_hi", {31'd0, radar_echo}, 32'd1);
    adv(4);
    chk("s7_count",   {16'd0, echo_count}, 32'd5);
    enable = 1'b1;
    adv(2);

    // Shot 8: reset in the 2nd echo cycle clears echo and count at once.
    target_distance = 32'd15;
    fire(300);
    adv(3);
    chk("s8_echo_2nd", {31'd0, radar_echo}, 32'd1);
    RST = 1'b1;
    #1;
    chk("s8_rst_echo",  {31'd0, radar_echo},      32'd0);
    chk("s8_rst_count", {16'd0, echo_count},      32'd0);
    chk("s8_rst_state", {30'd0, responder_state}, 32'd0);
    adv(1);
    RST = 1'b0;
    adv(10);
    chk("s8_idle_after", {30'd0, responder_state}, 32'd0);
    chk("s8_no_echo",    {31'd0, radar_echo},      32'd0);

    // Shot 9: count preloaded to 0xFFFF stays saturated after one more echo.
    force dut.echo_count = 16'hFFFF;
    adv(1);
    release dut.echo_count;
    adv(1);
    chk("s9_preload", {16'd0, echo_count}, 32'h0000FFFF);
    fire(300);
    adv(2);
    chk("s9_echo_hi", {31'd0, radar_echo}, 32'd1);
    adv(4);
    chk("s9_echo_lo", {31'd0, radar_echo}, 32'd0);
    chk("s9_sat",     {16'd0, echo_count}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
